// File: rtl/sample_holder_if.sv
// Bus bundle for sample_holder: serial capture side (bit strobe, data,
// word-end latch, channel index) plus the frame valid/ready output side.
interface sample_holder_if #(
    parameter int WIDTH    = 18,
    parameter int CHANNELS = 2,
    parameter int CH_BITS  = 1
);
    logic                      i_en;
    logic                      i_data;
    logic                      i_latch;
    logic [CH_BITS-1:0]        i_ch;
    logic                      i_ready;
    logic [WIDTH*CHANNELS-1:0] o_data;
    logic                      o_valid;
    logic                      o_overrun;
    logic                      o_short;

    // Producer / consumer side (drives the serial stream and ready)
    modport master (
        output i_en, i_data, i_latch, i_ch, i_ready,
        input  o_data, o_valid, o_overrun, o_short
    );

    // The sample holder itself
    modport slave (
        input  i_en, i_data, i_latch, i_ch, i_ready,
        output o_data, o_valid, o_overrun, o_short
    );
endinterface

// File: rtl/sample_holder.sv
// sample_holder: deserialises a MSB-first serial audio stream into WIDTH-bit
// words, stages one word per channel and presents a complete CHANNELS-word
// frame on a valid/ready output. A completed frame that finds the output
// still occupied is dropped and flagged with a one-cycle overrun pulse.
module sample_holder #(
    parameter int WIDTH    = 18,
    parameter int CHANNELS = 2,
    parameter int CH_BITS  = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    sample_holder_if.slave  bus
);

    localparam int                CNT_W   = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(WIDTH);

    logic [WIDTH-1:0]          r_sr;
    logic [CNT_W-1:0]          r_cnt;
    logic [WIDTH-1:0]          r_stg [CHANNELS];
    logic [CHANNELS-1:0]       r_mask;
    logic [WIDTH*CHANNELS-1:0] r_data;
    logic                      r_valid;
    logic                      r_overrun;
    logic                      r_short;

    logic [WIDTH-1:0]          w_shift;
    logic [CNT_W-1:0]          w_cntInc;
    logic [WIDTH-1:0]          w_word;
    logic [CNT_W-1:0]          w_bits;
    logic                      w_inRange;
    logic [CHANNELS-1:0]       w_hit;
    logic [CHANNELS-1:0]       w_maskNext;
    logic                      w_complete;
    logic                      w_free;
    logic [WIDTH*CHANNELS-1:0] w_frame;

    // Word assembly, channel decode and frame-completion detection; a bit
    // arriving on the same cycle as the latch is folded into the word.
    always_comb begin
        w_shift    = {r_sr[WIDTH-2:0], bus.i_data};
        w_cntInc   = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_W'(1);
        w_word     = bus.i_en ? w_shift : r_sr;
        w_bits     = bus.i_en ? w_cntInc : r_cnt;
        w_inRange  = (int'(bus.i_ch) < CHANNELS);
        w_hit      = '0;
        w_frame    = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_hit[k] = bus.i_latch && w_inRange && (int'(bus.i_ch) == k);
            w_frame[k*WIDTH +: WIDTH] = w_hit[k] ? w_word : r_stg[k];
        end
        w_maskNext = r_mask | w_hit;
        w_complete = bus.i_latch && (&w_maskNext);
        w_free     = !r_valid || bus.i_ready;
    end

    // Serial capture and per-channel staging; the mask clears whenever a
    // frame completes, whether it is delivered or dropped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sr    <= '0;
            r_cnt   <= '0;
            r_mask  <= '0;
            r_short <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                r_stg[k] <= '0;
            end
        end else begin
            r_short <= 1'b0;
            if (bus.i_latch) begin
                r_sr    <= '0;
                r_cnt   <= '0;
                r_short <= (w_bits != CNT_MAX);
                for (int k = 0; k < CHANNELS; k++) begin
                    if (w_hit[k]) begin
                        r_stg[k] <= w_word;
                    end
                end
                r_mask <= w_complete ? '0 : w_maskNext;
            end else if (bus.i_en) begin
                r_sr  <= w_shift;
                r_cnt <= w_cntInc;
            end
        end
    end

    // Output register: a new frame may load on the same edge as a transfer,
    // otherwise o_data is held until the consumer takes it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_valid && bus.i_ready) begin
                r_valid <= 1'b0;
            end
            if (w_complete) begin
                if (w_free) begin
                    r_data  <= w_frame;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign bus.o_data    = r_data;
    assign bus.o_valid   = r_valid;
    assign bus.o_overrun = r_overrun;
    assign bus.o_short   = r_short;

endmodule

// File: tb/tb_sample_holder.sv
// Directed bench for sample_holder: a 2-channel and a 3-channel instance
// share one stimulus stream; each phase checks only the instance it targets.
module tb_sample_holder;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       dat;
    logic       latch;
    logic [1:0] ch;
    logic       ready;

    int nChecks;
    int nBad;

    sample_holder_if #(.WIDTH(18), .CHANNELS(2), .CH_BITS(1)) busA ();
    sample_holder_if #(.WIDTH(18), .CHANNELS(3), .CH_BITS(2)) busB ();

    assign busA.i_en    = en;
    assign busA.i_data  = dat;
    assign busA.i_latch = latch;
    assign busA.i_ch    = ch[0:0];
    assign busA.i_ready = ready;

    assign busB.i_en    = en;
    assign busB.i_data  = dat;
    assign busB.i_latch = latch;
    assign busB.i_ch    = ch;
    assign busB.i_ready = ready;

    sample_holder #(.WIDTH(18), .CHANNELS(2), .CH_BITS(1)) dutA (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (busA.slave)
    );

    sample_holder #(.WIDTH(18), .CHANNELS(3), .CH_BITS(2)) dutB (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (busB.slave)
    );

    // Free-running clock, 10 time-unit period
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nBad++;
            $display("[TB] FAIL %s: got 'h%0h, want 'h%0h", tag, observed, expected);
        end
    endtask

    // Drive one input vector and advance to 1 time unit past the next edge
    task automatic applyStimulus(input logic e, input logic d, input logic l,
                                 input logic [1:0] c);
        en    = e;
        dat   = d;
        latch = l;
        ch    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic shiftWord(input logic [31:0] value, input int nBits);
        for (int i = nBits - 1; i >= 0; i--) begin
            applyStimulus(1'b1, value[i], 1'b0, 2'd0);
        end
    endtask

    task automatic latchWord(input logic [1:0] c);
        applyStimulus(1'b0, 1'b0, 1'b1, c);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    initial begin
        logic [31:0] v;
        nChecks = 0;
        nBad    = 0;
        clk     = 1'b0;
        rst_n   = 1'b0;
        en      = 1'b0;
        dat     = 1'b0;
        latch   = 1'b0;
        ch      = 2'd0;
        ready   = 1'b0;

        // Power-on reset
        idle();
        idle();
        checkOutput("rst_valid",   64'(busA.o_valid),   64'd0);
        checkOutput("rst_data",    64'(busA.o_data),    64'd0);
        checkOutput("rst_overrun", 64'(busA.o_overrun), 64'd0);
        checkOutput("rst_short",   64'(busA.o_short),   64'd0);
        rst_n = 1'b1;

        // Hold a frame (ready low), then reset mid-word without a clock edge
        shiftWord(32'h12345, 18);
        latchWord(2'd0);
        shiftWord(32'h0ABCD, 18);
        latchWord(2'd1);
        checkOutput("held_valid", 64'(busA.o_valid), 64'd1);
        checkOutput("held_data",  64'(busA.o_data),  64'h2AF352345);
        shiftWord(32'h1FF, 9);
        en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", 64'(busA.o_valid), 64'd0);
        checkOutput("async_rst_data",  64'(busA.o_data),  64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Mid-word bits must be gone: 9 zeros give a short zero word
        shiftWord(32'h0, 9);
        latchWord(2'd0);
        checkOutput("discard_short", 64'(busA.o_short), 64'd1);
        checkOutput("discard_valid", 64'(busA.o_valid), 64'd0);
        idle();
        checkOutput("short_pulse_end", 64'(busA.o_short), 64'd0);
        shiftWord(32'h3FFFF, 18);
        latchWord(2'd0);
        checkOutput("ch0_only_valid", 64'(busA.o_valid), 64'd0);
        checkOutput("ch0_full_short", 64'(busA.o_short), 64'd0);
        ready = 1'b1;
        shiftWord(32'h00001, 18);
        latchWord(2'd1);
        checkOutput("after_rst_valid", 64'(busA.o_valid), 64'd1);
        checkOutput("after_rst_data",  64'(busA.o_data),  64'h00007FFFF);
        idle();
        checkOutput("after_rst_drain", 64'(busA.o_valid), 64'd0);

        // Basic frame with ready high
        shiftWord(32'h2AAAA, 18);
        latchWord(2'd0);
        shiftWord(32'h15555, 18);
        latchWord(2'd1);
        checkOutput("frame_valid", 64'(busA.o_valid), 64'd1);
        checkOutput("frame_data",  64'(busA.o_data),  64'h55556AAAA);
        idle();
        checkOutput("frame_drain", 64'(busA.o_valid), 64'd0);

        // Over-long word keeps last 18 bits; short word right-justified
        shiftWord(32'hFFFFF, 20);
        latchWord(2'd0);
        checkOutput("long_short", 64'(busA.o_short), 64'd0);
        shiftWord(32'h0FFFF, 16);
        latchWord(2'd1);
        checkOutput("len16_short", 64'(busA.o_short), 64'd1);
        checkOutput("len_data",    64'(busA.o_data),  64'h3FFFFFFFF);
        idle();
        checkOutput("len16_pulse_end", 64'(busA.o_short), 64'd0);

        // Bit and latch on the same edge; next word counts from zero
        v = 32'h2AAAA;
        shiftWord(v >> 1, 17);
        applyStimulus(1'b1, v[0], 1'b1, 2'd0);
        checkOutput("simul_short", 64'(busA.o_short), 64'd0);
        shiftWord(32'h15555, 17);
        latchWord(2'd1);
        checkOutput("recount_short", 64'(busA.o_short), 64'd1);
        checkOutput("simul_data",    64'(busA.o_data),  64'h55556AAAA);
        idle();

        // Backpressure: second frame dropped, first one held then accepted
        ready = 1'b0;
        shiftWord(32'h00001, 18);
        latchWord(2'd0);
        shiftWord(32'h00002, 18);
        latchWord(2'd1);
        checkOutput("bp_a_valid", 64'(busA.o_valid), 64'd1);
        checkOutput("bp_a_data",  64'(busA.o_data),  64'h000080001);
        shiftWord(32'h00003, 18);
        latchWord(2'd0);
        shiftWord(32'h00004, 18);
        latchWord(2'd1);
        checkOutput("bp_overrun",  64'(busA.o_overrun), 64'd1);
        checkOutput("bp_hold",     64'(busA.o_data),    64'h000080001);
        checkOutput("bp_still_vd", 64'(busA.o_valid),   64'd1);
        idle();
        checkOutput("bp_ovr_end", 64'(busA.o_overrun), 64'd0);
        ready = 1'b1;
        idle();
        checkOutput("bp_accepted", 64'(busA.o_valid), 64'd0);

        // Three-channel instance: out-of-range channel is discarded
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        shiftWord(32'hF, 4);
        latchWord(2'd3);
        checkOutput("oor_short", 64'(busB.o_short), 64'd1);
        checkOutput("oor_valid", 64'(busB.o_valid), 64'd0);
        shiftWord(32'h00003, 18);
        latchWord(2'd0);
        shiftWord(32'h00005, 18);
        latchWord(2'd1);
        checkOutput("three_partial", 64'(busB.o_valid), 64'd0);
        shiftWord(32'h00007, 18);
        latchWord(2'd2);
        checkOutput("three_valid", 64'(busB.o_valid), 64'd1);
        checkOutput("three_data",  64'(busB.o_data),  64'h7000140003);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule

// File: doc/sample_holder.md
# sample_holder

Parametrised successor to the single-bit enable register: deserialises the DAC-side serial audio stream into WIDTH-bit words, stages one word per channel, and presents a complete multi-channel frame on a valid/ready output. Sits between the serial capture front end (bit strobe, data, latch strobe) and the I2S formatter, decoupling word arrival from frame consumption.

## Interface
- WIDTH, 18, bits per sample word (≥2)
- CHANNELS, 2, words per frame (≥1)
- CH_BITS, 1, width of channel index; ≥1 and ≥ceil(log2(CHANNELS))

- i_clk  in  1  single clock, all state updates on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_en  in  1  bit strobe; i_data sampled when high
- i_data  in  1  serial data, MSB first
- i_latch  in  1  one-cycle word-end strobe
- i_ch  in  CH_BITS  channel index of word ending on i_latch
- i_ready  in  1  consumer accepts frame
- o_data  out  WIDTH*CHANNELS  frame; channel k at bits [k*WIDTH +: WIDTH]
- o_valid  out  1  frame available
- o_overrun  out  1  one-cycle pulse: completed frame dropped
- o_short  out  1  one-cycle pulse: latched word had < WIDTH bits

## Operation
- Shift register sr[WIDTH-1:0], bit counter cnt (saturates at WIDTH), staging words stg[CHANNELS], staged mask m[CHANNELS].
- i_en only: sr <= {sr[WIDTH-2:0], i_data}; cnt <= min(cnt+1, WIDTH). More than WIDTH bits: only last WIDTH kept.
- i_latch: word w = (i_en ? shifted value : sr), bits counted k = (i_en ? min(cnt+1,WIDTH) : cnt). sr <= 0, cnt <= 0. Short words are right-justified, upper bits zero.
- k < WIDTH on latch: o_short pulses next cycle (word still staged).
- i_ch < CHANNELS: stg[i_ch] <= w, m[i_ch] <= 1. Re-latch of an already staged channel overwrites, mask unchanged. i_ch ≥ CHANNELS: word discarded, no mask change, o_short still reported.
- Frame complete when m (including this latch) is all ones:
  - output free (o_valid==0 or i_ready==1): o_data <= staging incl. w, o_valid <= 1, m <= 0.
  - output busy (o_valid==1, i_ready==0): frame dropped, o_overrun pulses, m <= 0, o_data/o_valid unchanged.
- Handshake: transfer on edge with o_valid&&i_ready. o_valid falls after transfer unless a new frame loads on same edge (stays 1, new data). o_data stable while o_valid && !i_ready.
- i_latch with i_en=0 and cnt=0: zero word, o_short pulses.

## Timing
- Reset (async assert, sync-to-clock release acceptable upstream): sr, cnt, stg, m, o_data=0, o_valid=0, o_overrun=0, o_short=0; takes effect immediately, mid-word data discarded.
- Bit shift: visible in sr one edge after i_en.
- Latch to o_valid: final latch at edge N → o_valid/o_data updated at edge N (visible cycle N+1); o_overrun/o_short high for exactly the cycle after edge N.
- i_latch on consecutive cycles permitted; one frame per CHANNELS latches max.
- i_ready ignored while o_valid=0.

## Test plan
- Reset mid-stream: 9 bits shifted, drop i_rst_n without clock → all outputs 0 at once; after release, 18 bits of 0x3FFFF + latch ch0 → no o_valid until ch1 latched.
- Frame (WIDTH=18, CHANNELS=2, i_ready=1): 0x2AAAA → ch0, 0x15555 → ch1 → o_valid one cycle after ch1 latch, o_data=36'h55556AAAA, o_valid low next cycle.
- Length: 20 bits 0xFFFFF then latch → word 0x3FFFF, no o_short; 16 bits 0xFFFF → word 0x0FFFF, o_short one-cycle pulse.
- Simultaneous i_en+i_latch on 18th bit → bit included, word 0x2AAAA, no o_short; next word counts from 0.
- Backpressure: i_ready=0, frame A {0x00001,0x00002} then frame B → o_overrun pulse, o_data holds A; raise i_ready → A accepted, o_valid low.
- Out-of-range (CHANNELS=3, CH_BITS=2): latch with i_ch=3 → no mask change, no frame; ch0..2 then complete normally.
